// File: rtl/ble_pkt_spi_master.sv
// SPI mode-0 packet master: sends CMD_BYTE, the payload size, then payload bytes
// fetched from a synchronous memory, with a fixed sclk-low gap between bytes.
module ble_pkt_spi_master #(
  parameter int          CLK_DIV  = 4,
  parameter int          GAP_CYC  = 8,
  parameter logic [7:0]  CMD_BYTE = 8'hAA
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] pkt_size,
  output logic       mem_re,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_q,
  output logic       spi_sclk,
  output logic       spi_cs,
  output logic       spi_mosi,
  output logic       busy,
  output logic       done
);

  localparam int PH_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int PH_W   = $clog2(PH_MAX);

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, GAP, HOLD, DONE} state_t;

  state_t          state, state_next;
  logic [PH_W-1:0] ph_cnt;
  logic [2:0]      bit_cnt;
  logic [8:0]      byte_cnt;
  logic            high;
  logic [7:0]      sh_reg;
  logic [7:0]      nxt_byte;
  logic [7:0]      size_q;
  logic [7:0]      addr_q;
  logic            cap_pend;
  logic            ph_end;
  logic            gap_end;
  logic            last_byte;
  logic            fetch_ok;

  assign ph_end    = (ph_cnt == PH_W'(CLK_DIV - 1));
  assign gap_end   = (ph_cnt == PH_W'(GAP_CYC - 1));
  assign last_byte = (byte_cnt == ({1'b0, size_q} + 9'd1));
  // FETCH is the first (low) cycle of every byte; bytes 1..size prefetch payload byte_cnt-1.
  assign fetch_ok  = (state == FETCH) && (byte_cnt != 9'd0) && (byte_cnt <= {1'b0, size_q});

  assign mem_re   = fetch_ok;
  assign mem_addr = fetch_ok ? (byte_cnt[7:0] - 8'd1) : addr_q;
  assign busy     = (state == FETCH) || (state == SHIFT) || (state == GAP) || (state == HOLD);
  assign spi_cs   = !busy;
  assign done     = (state == DONE);
  assign spi_sclk = high;
  assign spi_mosi = sh_reg[7];

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = FETCH;
      FETCH,
      SHIFT: begin
        state_next = SHIFT;
        if (ph_end && high && (bit_cnt == 3'd7)) state_next = last_byte ? HOLD : GAP;
      end
      GAP:   if (gap_end) state_next = FETCH;
      HOLD:  if (ph_end) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_cnt   <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      high     <= 1'b0;
      sh_reg   <= '0;
      nxt_byte <= '0;
      size_q   <= '0;
      addr_q   <= '0;
      cap_pend <= 1'b0;
    end else begin
      cap_pend <= mem_re;
      if (cap_pend) nxt_byte <= mem_q;
      if (mem_re)   addr_q   <= mem_addr;
      case (state)
        IDLE: begin
          if (start) begin
            size_q   <= pkt_size;
            sh_reg   <= CMD_BYTE;
            byte_cnt <= '0;
            bit_cnt  <= '0;
            ph_cnt   <= '0;
            high     <= 1'b0;
          end
        end
        FETCH, SHIFT: begin
          if (ph_end) begin
            ph_cnt <= '0;
            high   <= !high;
            // Shifting on the high->low transition makes mosi change on the falling edge.
            if (high && (bit_cnt != 3'd7)) begin
              bit_cnt <= bit_cnt + 3'd1;
              sh_reg  <= {sh_reg[6:0], 1'b0};
            end
          end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end
        end
        GAP: begin
          if (gap_end) begin
            ph_cnt   <= '0;
            bit_cnt  <= '0;
            byte_cnt <= byte_cnt + 9'd1;
            sh_reg   <= (byte_cnt == 9'd0) ? size_q : nxt_byte;
          end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end
        end
        HOLD: begin
          if (!ph_end) ph_cnt <= ph_cnt + PH_W'(1);
        end
        DONE: begin
          ph_cnt <= '0;
          sh_reg <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ble_pkt_spi_master.md
BLE_PKT_SPI_MASTER -- requirements
Module: ble_pkt_spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per sclk half-period (>=2).
REQ-002 SHALL have parameter GAP_CYC, default 8, meaning clk cycles of sclk-low idle between bytes, with cs held low (>=2).
REQ-003 SHALL have parameter CMD_BYTE, default 8'hAA, meaning the packet-start command byte.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: frame request, sampled only in IDLE.
REQ-007 SHALL have port pkt_size, input, 8 bits: payload byte count, latched on an accepted start.
REQ-008 SHALL have port mem_re, output, 1 bit: payload memory read strobe.
REQ-009 SHALL have port mem_addr, output, 8 bits: payload memory address.
REQ-010 SHALL have port mem_q, input, 8 bits: memory read data, valid the cycle after mem_re.
REQ-011 SHALL have port spi_sclk, output, 1 bit: SPI clock, mode 0 (idle low).
REQ-012 SHALL have port spi_cs, output, 1 bit: active-low chip select.
REQ-013 SHALL have port spi_mosi, output, 1 bit: serial data, MSB first.
REQ-014 SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until done.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-016 SHALL implement states IDLE, FETCH, SHIFT, GAP, HOLD and DONE.
REQ-017 SHALL accept start only in IDLE; start while busy SHALL be ignored.
REQ-018 SHALL transmit each frame as CMD_BYTE, then pkt_size, then payload bytes from addresses 0..pkt_size-1 in order (N = pkt_size+2 bytes).
REQ-019 SHALL drop spi_cs low and drive spi_mosi with bit 7 of CMD_BYTE in the cycle after start is accepted.
REQ-020 SHALL send each bit as CLK_DIV cycles of sclk low, then CLK_DIV cycles of sclk high.
REQ-021 SHALL change spi_mosi only at the first cycle of each low phase (the falling edge) and hold it stable through the high phase.
REQ-022 SHALL insert exactly GAP_CYC cycles of sclk low between bytes, with spi_cs held low and spi_mosi held at the previous LSB.
REQ-023 SHALL, after the last byte's final high phase, hold sclk low for CLK_DIV cycles (HOLD), then raise spi_cs, pulse done for one cycle and clear busy in that same cycle.
REQ-024 SHALL keep spi_cs low for exactly N*16*CLK_DIV + (N-1)*GAP_CYC + CLK_DIV cycles.
REQ-025 SHALL issue the fetch for payload byte k as a one-cycle mem_re pulse with mem_addr=k in the first SHIFT cycle of the preceding byte.
REQ-026 SHALL capture mem_q one cycle after each mem_re pulse into a next-byte register.
REQ-027 SHALL pulse mem_re exactly pkt_size times per frame, each address exactly once.
REQ-028 SHALL hold mem_addr at its last value whenever mem_re is low.
REQ-029 SHALL, when pkt_size=0, send only CMD_BYTE and 8'h00 with no mem_re pulse.
REQ-030 SHALL, when pkt_size=255, send 257 bytes with mem_addr reaching 254 and no address wrap.
REQ-031 SHALL use the latched size for the whole frame; pkt_size changes mid-frame SHALL have no effect.
REQ-032 SHALL hold at least one IDLE cycle after DONE; start asserted in the DONE cycle SHALL be ignored.
REQ-033 SHALL count bits (3 bits), bytes (9 bits) and phases without overflow at the parameter limits.

Reset
REQ-034 SHALL, while rst is high, immediately force spi_cs=1, spi_sclk=0, spi_mosi=0, mem_re=0, mem_addr=0, busy=0, done=0 and the state to IDLE.
REQ-035 SHALL, on reset mid-frame, abort the frame with no done pulse, and SHALL accept a new start normally after release.

Verification
REQ-036 SHALL verify CLK_DIV=2, GAP_CYC=4, pkt_size=2, mem={0x5A,0xC3} -> MOSI bytes AA,02,5A,C3, cs low for 142 cycles, mem_re at addresses 0 then 1, one done pulse.
REQ-037 SHALL verify pkt_size=0 -> bytes AA,00, zero mem_re pulses, cs low for 70 cycles (CLK_DIV=2, GAP=4).
REQ-038 SHALL verify start pulsed every cycle during a frame -> exactly one frame sent; a new frame begins only after the IDLE cycle following done.
REQ-039 SHALL verify rst asserted during byte 3 -> cs=1 and sclk=0 in the same cycle, no done pulse, and a subsequent frame is correct.
REQ-040 SHALL verify pkt_size=255 with mem[k]=k -> 257 bytes, last payload byte 0xFE, 255 mem_re pulses.
REQ-041 SHALL verify a loopback through the SPI slave receive path -> the slave memory holds the payload at addresses 0..pkt_size-1.
